// File: rtl/register_8b_pkg.sv
// Shared constants and types for the register_8b storage element family.
package register_8b_pkg;

  localparam int unsigned REG_DEFAULT_WIDTH = 8;
  localparam int unsigned REG_MAX_STAGES    = 8;
  localparam int unsigned REG_MAX_WIDTH     = 64;

  // Default 8-bit data word.
  typedef logic [REG_DEFAULT_WIDTH-1:0] reg_word_t;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/register_8b_stage.sv
// Single WIDTH-bit pipeline flop with asynchronous active-high reset to RESET_VALUE.
module register_8b_stage #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on every rising edge; no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end

endmodule

// File: rtl/register_8b.sv
// Parameterised pipelined register: STAGES flops between in and out, plus a
// fill counter driving valid. Optional change detector enabled by defining
// REGISTER_8B_CHANGE_EN (adds the changed output).
module register_8b
  import register_8b_pkg::*;
#(
  parameter int unsigned              WIDTH       = REG_DEFAULT_WIDTH,
  parameter logic [REG_MAX_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned              STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
`ifdef REGISTER_8B_CHANGE_EN
  output logic             changed,
`endif
  output logic             valid
);

  localparam int unsigned      CNT_W  = cnt_width(REG_MAX_STAGES);
  localparam logic [WIDTH-1:0] RST_W  = RESET_VALUE[WIDTH-1:0];
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(STAGES);

  // Reject illegal configurations at elaboration.
  generate
    if (WIDTH < 1 || WIDTH > REG_MAX_WIDTH) begin : g_bad_width
      $error("register_8b: WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > REG_MAX_STAGES) begin : g_bad_stages
      $error("register_8b: STAGES must be in 1..8");
    end
  endgenerate

  logic [WIDTH-1:0] s [STAGES];

  // Chain of identical stages: s[0] takes in, s[k] takes s[k-1].
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        register_8b_stage #(.WIDTH(WIDTH), .RESET_VALUE(RST_W)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (in),
          .q   (s[k])
        );
      end else begin : g_next
        register_8b_stage #(.WIDTH(WIDTH), .RESET_VALUE(RST_W)) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (s[k-1]),
          .q   (s[k])
        );
      end
    end
  endgenerate

  assign out = s[STAGES-1];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Fill counter next value: count edges since reset, saturating at STAGES.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
  end

  // Fill counter and registered valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      valid <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      valid <= (cnt_d == FULL);
    end
  end

`ifdef REGISTER_8B_CHANGE_EN
  logic [WIDTH-1:0] last_d;

  // Value the last stage loads on the next edge.
  generate
    if (STAGES == 1) begin : g_last_in
      assign last_d = in;
    end else begin : g_last_chain
      assign last_d = s[STAGES-2];
    end
  endgenerate

  // The pre-edge out acts as prev: changed is registered so it pulses for the
  // cycle after an edge that alters out, and only when out was already valid,
  // which keeps it low on the first valid cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed <= 1'b0;
    else     changed <= valid && (last_d != out);
  end
`endif

endmodule

// File: tb/tb_register_8b.sv
// Self-checking bench for register_8b: three configurations share stimulus and
// are compared against a history-queue reference model.
module tb_register_8b;

  logic       clk;
  logic       rst;
  logic [7:0] in;

  logic [7:0] out1, out3, out_a5;
  logic       valid1, valid3, valid_a5;
`ifdef REGISTER_8B_CHANGE_EN
  logic       changed1, changed3, changed_a5;
`endif

  int vectors = 0;
  int errs    = 0;

  // Every input sampled at a rising edge since the last reset, oldest first.
  logic [7:0] hist [$];

  register_8b #(.WIDTH(8), .RESET_VALUE(64'h0), .STAGES(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out1),
`ifdef REGISTER_8B_CHANGE_EN
    .changed (changed1),
`endif
    .valid   (valid1)
  );

  register_8b #(.WIDTH(8), .RESET_VALUE(64'h0), .STAGES(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out3),
`ifdef REGISTER_8B_CHANGE_EN
    .changed (changed3),
`endif
    .valid   (valid3)
  );

  register_8b #(.WIDTH(8), .RESET_VALUE(64'hA5), .STAGES(1)) dut_a5 (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out_a5),
`ifdef REGISTER_8B_CHANGE_EN
    .changed (changed_a5),
`endif
    .valid   (valid_a5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected out of an s-stage register after n edges since reset.
  function automatic logic [7:0] model_out(input int s, input int n, input logic [7:0] rv);
    if (n >= s) return hist[n-s];
    return rv;
  endfunction

  function automatic logic model_changed(input int s, input int n);
    if (n - 1 < s) return 1'b0;
    return model_out(s, n, 8'h00) != model_out(s, n - 1, 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = hist.size();
    chk({tag, " out1"},    64'(out1),    64'(model_out(1, n, 8'h00)));
    chk({tag, " valid1"},  64'(valid1),  64'(n >= 1));
    chk({tag, " out3"},    64'(out3),    64'(model_out(3, n, 8'h00)));
    chk({tag, " valid3"},  64'(valid3),  64'(n >= 3));
    chk({tag, " out_a5"},  64'(out_a5),  64'(model_out(1, n, 8'hA5)));
    chk({tag, " valid_a5"},64'(valid_a5),64'(n >= 1));
`ifdef REGISTER_8B_CHANGE_EN
    chk({tag, " changed1"}, 64'(changed1), 64'(model_changed(1, n)));
    chk({tag, " changed3"}, 64'(changed3), 64'(model_changed(3, n)));
`endif
  endtask

  // One rising edge with rst low; record the sampled input, check just after.
  task automatic tick(input string tag);
    @(posedge clk);
    hist.push_back(in);
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    hist.delete();
    check_all("async_rst");
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in  = 8'd9;
    #2;
    chk("reset out1",   64'(out1),   64'h00);
    chk("reset valid1", 64'(valid1), 64'h0);
    chk("reset out_a5", 64'(out_a5), 64'hA5);
    check_all("reset");

    // Capture and hold.
    @(negedge clk) rst = 1'b0;
    in = 8'd9;
    tick("capture");
    chk("capture out1",   64'(out1),   64'd9);
    chk("capture valid1", 64'(valid1), 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick("hold");
      chk("hold out1", 64'(out1), 64'd9);
    end

    // Latency through three stages with fill from reset.
    pulse_reset();
    in = 8'd1; tick("lat");
    in = 8'd3; tick("lat");
    chk("lat valid3 early", 64'(valid3), 64'h0);
    in = 8'd5; tick("lat");
    chk("lat valid3", 64'(valid3), 64'h1);
    chk("lat out3 first", 64'(out3), 64'd1);
    in = 8'd7; tick("lat");
    chk("lat out3 second", 64'(out3), 64'd3);
    in = 8'd0; tick("lat");
    chk("lat out3 third", 64'(out3), 64'd5);
    tick("lat");
    chk("lat out3 fourth", 64'(out3), 64'd7);

    // Mid-operation reset then recapture.
    in = 8'd10; tick("mid");
    chk("mid out1 before", 64'(out1), 64'd10);
    pulse_reset();
    chk("mid out1 cleared", 64'(out1), 64'd0);
    in = 8'd4; tick("mid_after");
    chk("mid out1 recapture", 64'(out1), 64'd4);

    // Change detection sequence.
    pulse_reset();
    in = 8'd2; tick("chg");
`ifdef REGISTER_8B_CHANGE_EN
    chk("chg first", 64'(changed1), 64'h0);
`endif
    in = 8'd2; tick("chg");
`ifdef REGISTER_8B_CHANGE_EN
    chk("chg same", 64'(changed1), 64'h0);
`endif
    in = 8'd5; tick("chg");
`ifdef REGISTER_8B_CHANGE_EN
    chk("chg diff", 64'(changed1), 64'h1);
`endif
    in = 8'd5; tick("chg");
`ifdef REGISTER_8B_CHANGE_EN
    chk("chg settle", 64'(changed1), 64'h0);
`endif

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) in = out1;
      tick("rand");
      if ($urandom_range(0, 24) == 0) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/register_8b.md
# register_8b

Clocked storage element holding a parameterised-width data word, 8 bits by default. It captures `in` on every rising clock edge and presents the stored value on `out`. Large arrays of it form register banks such as operand memories, where it isolates constant or slowly changing source values behind a clocked boundary. Latency is configurable as a short pipeline of identical stages.

## Interface
- `WIDTH`, default 8: data width in bits; legal range 1..64.
- `RESET_VALUE`, default 0: value loaded into every stage on reset; truncated to `WIDTH` bits.
- `STAGES`, default 1: number of register stages between `in` and `out`; legal range 1..8.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `in`  input  WIDTH  data to capture.
- `out`  output  WIDTH  registered data, driven directly from the last stage flop.
- `valid`  output  1  high once `STAGES` edges have occurred since reset release; marks `out` as carrying real captured data.
- `changed`  output  1  present only with `REGISTER_8B_CHANGE_EN`; see Configuration.

## Operation
- Each stage `s[k]` holds one `WIDTH`-bit word.
  - `s[0] <= in` on every rising edge.
  - `s[k] <= s[k-1]` for k ≥ 1.
  - `out = s[STAGES-1]`.
- There is no enable. Every edge captures, so a constant `in` yields a constant `out`.
- A fill counter saturates at `STAGES`.
  - It increments once per edge after reset release.
  - `valid` is high when the counter equals `STAGES`.
- No arithmetic is performed. Data passes bit-exact with no sign or width conversion.
- `out` is never combinationally dependent on `in`.

## Timing
- Reset is asynchronous and active-high.
  - While `rst` is high, all stages equal `RESET_VALUE`, the counter is 0, `valid` is 0 and `changed` is 0.
  - These values appear immediately on assertion, with no clock required.
- On reset release, the first rising edge with `rst` low captures `in`.
- With `STAGES` = 1:
  - `out` equals the `in` value sampled at edge N, visible after edge N.
  - `valid` goes high after the first post-reset edge.
- Latency is `STAGES` clock edges from `in` to `out`.
- Reset asserted mid-pipeline discards all in-flight data. Refill restarts from zero after release.
- If reset releases coincident with a clock edge, that edge does not capture. The first capture is the next edge.

## Configuration
- `REGISTER_8B_CHANGE_EN` defined:
  - Adds a `WIDTH`-bit register `prev` that tracks `out` delayed by one edge.
  - Adds output `changed = valid && (out != prev)`.
  - `changed` pulses high for exactly one cycle after each edge that alters `out`.
  - `changed` is 0 on the first valid cycle after reset.
- Macro undefined:
  - The `changed` port and the `prev` register do not exist.
  - Area is `STAGES`×`WIDTH` flops plus the counter.

## Structure
- A shared package `register_8b_pkg` holds:
  - Constants `REG_DEFAULT_WIDTH` = 8, `REG_MAX_STAGES` = 8 and `REG_MAX_WIDTH` = 64.
  - A `reg_word_t` typedef for the default 8-bit word.
- One sub-module, `register_8b_stage`, is natural: a single `WIDTH`-bit flop with asynchronous reset to `RESET_VALUE`. The top generates `STAGES` instances of it in a chain.
- Out-of-range parameters are rejected at elaboration.

## Test plan
- Reset: assert `rst` with `in` = 8'd9 and no clock edges → `out` = 8'd0 and `valid` = 0 immediately.
- Capture: release `rst`, drive `in` = 8'd9 and clock once → `out` = 8'd9 and `valid` = 1; hold `in` for 5 edges → `out` stays 8'd9.
- Latency: set `STAGES` = 3 and drive the sequence 1, 3, 5, 7 → `out` shows 1, 3, 5, 7 starting 3 edges after each input, and `valid` rises after the 3rd edge.
- Mid-operation reset: `out` = 8'd10, then pulse `rst` between edges → `out` = 8'd0 at once, and the next edge with `in` = 8'd4 gives `out` = 8'd4.
- `RESET_VALUE` = 8'hA5 with `WIDTH` = 8 → `out` = 8'hA5 during reset.
- Change detection (`REGISTER_8B_CHANGE_EN`): drive `in` = 2, 2, 5, 5 → `changed` is 0, 0, 1, 0 on the cycles following each update.
